// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - game event / move strobe / redraw handshake bundle
interface game_sequencer_if;
  logic       start;
  logic       pause;
  logic       goodColl;
  logic       badColl;
  logic       isGameComplete;
  logic       draw_done;
  logic       sync;
  logic       s_reset;
  logic       draw_req;
  logic [2:0] state;
  logic [2:0] speed_level;
  logic       overrun;

  // The sequencer consumes game events and produces the move strobe and redraw request
  modport master (
    input  start, pause, goodColl, badColl, isGameComplete, draw_done,
    output sync, s_reset, draw_req, state, speed_level, overrun
  );

  // Surrounding datapath / image generator view
  modport slave (
    output start, pause, goodColl, badColl, isGameComplete, draw_done,
    input  sync, s_reset, draw_req, state, speed_level, overrun
  );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - snake game sequencer: move tick, redraw handshake, pause, end states, speed
module game_sequencer #(
  parameter int TICK_BASE        = 1500000,
  parameter int SPEED_STEP       = 150000,
  parameter int SPEED_LEVELS     = 8,
  parameter int APPLES_PER_LEVEL = 4
) (
  input logic              clk,
  input logic              nrst,
  game_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAW  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } state_t;

  localparam int              AW         = (APPLES_PER_LEVEL > 1) ? $clog2(APPLES_PER_LEVEL) : 1;
  localparam logic [2:0]      LEVEL_MAX  = 3'(SPEED_LEVELS - 1);
  localparam logic [AW-1:0]   APPLE_LAST = AW'(APPLES_PER_LEVEL - 1);

  state_t        state_q;
  logic [23:0]   cnt;
  logic [23:0]   period;
  logic          tick_pending;
  logic          pause_pending;
  logic [AW-1:0] apple_cnt;
  logic [2:0]    speed_level;
  logic          sync_q;
  logic          s_reset_q;
  logic          draw_req_q;
  logic          overrun_q;

  logic [23:0]   next_period;
  logic          expire;
  logic          terminal;
  state_t        term_state;
  logic          restart;
  logic          apple_hit;

  assign next_period = 24'(TICK_BASE) - 24'(speed_level) * 24'(SPEED_STEP);
  assign expire      = (cnt == period - 24'd1);
  assign terminal    = bus.badColl | bus.isGameComplete;
  assign term_state  = bus.badColl ? OVER : WIN;
  assign restart     = bus.start && (state_q == IDLE || state_q == OVER || state_q == WIN);
  assign apple_hit   = bus.goodColl && !terminal && (state_q == RUN || state_q == DRAW);

  // Main game FSM: tick counting, redraw handshake, pause and terminal handling
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      cnt           <= '0;
      period        <= 24'(TICK_BASE);
      tick_pending  <= 1'b0;
      pause_pending <= 1'b0;
      sync_q        <= 1'b0;
      s_reset_q     <= 1'b0;
      draw_req_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync_q    <= 1'b0;
      s_reset_q <= 1'b0;
      case (state_q)
        IDLE, OVER, WIN: begin
          if (bus.start) begin
            // A fresh game always starts at level 0, so the base period applies
            state_q       <= RUN;
            s_reset_q     <= 1'b1;
            cnt           <= '0;
            period        <= 24'(TICK_BASE);
            tick_pending  <= 1'b0;
            pause_pending <= 1'b0;
            draw_req_q    <= 1'b0;
            overrun_q     <= 1'b0;
          end
        end
        RUN: begin
          if (terminal) begin
            state_q       <= term_state;
            draw_req_q    <= 1'b0;
            tick_pending  <= 1'b0;
            pause_pending <= 1'b0;
          end else if (bus.pause) begin
            // Counter holds its value so the move resumes where it left off
            state_q <= PAUSE;
          end else if (tick_pending || expire) begin
            sync_q       <= 1'b1;
            draw_req_q   <= 1'b1;
            state_q      <= DRAW;
            cnt          <= '0;
            period       <= next_period;
            tick_pending <= 1'b0;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        DRAW: begin
          if (terminal) begin
            state_q       <= term_state;
            draw_req_q    <= 1'b0;
            tick_pending  <= 1'b0;
            pause_pending <= 1'b0;
          end else begin
            // The tick keeps running behind the redraw; a late frame parks it
            if (tick_pending) begin
              cnt <= '0;
            end else if (expire) begin
              cnt          <= '0;
              tick_pending <= 1'b1;
              overrun_q    <= 1'b1;
            end else begin
              cnt <= cnt + 24'd1;
            end
            if (bus.draw_done) begin
              draw_req_q    <= 1'b0;
              pause_pending <= 1'b0;
              state_q       <= (pause_pending ^ bus.pause) ? PAUSE : RUN;
            end else if (bus.pause) begin
              pause_pending <= ~pause_pending;
            end
          end
        end
        PAUSE: begin
          if (terminal) begin
            state_q       <= term_state;
            draw_req_q    <= 1'b0;
            tick_pending  <= 1'b0;
            pause_pending <= 1'b0;
          end else if (bus.pause) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Speed ladder: every APPLES_PER_LEVEL apples bump the level, saturating at the top
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      apple_cnt   <= '0;
      speed_level <= '0;
    end else if (restart) begin
      apple_cnt   <= '0;
      speed_level <= '0;
    end else if (apple_hit) begin
      if (apple_cnt == APPLE_LAST) begin
        apple_cnt <= '0;
        if (speed_level != LEVEL_MAX) begin
          speed_level <= speed_level + 3'd1;
        end
      end else begin
        apple_cnt <= apple_cnt + AW'(1);
      end
    end
  end

  assign bus.sync        = sync_q;
  assign bus.s_reset     = s_reset_q;
  assign bus.draw_req    = draw_req_q;
  assign bus.state       = state_q;
  assign bus.speed_level = speed_level;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
module tb_game_sequencer;

  localparam logic [5:0] P_START = 6'b100000;
  localparam logic [5:0] P_PAUSE = 6'b010000;
  localparam logic [5:0] P_GOOD  = 6'b001000;
  localparam logic [5:0] P_BAD   = 6'b000100;
  localparam logic [5:0] P_WIN   = 6'b000010;
  localparam logic [5:0] P_DONE  = 6'b000001;

  logic clk;
  logic nrst;
  int   cyc;
  int   checks;
  int   errors;
  int   exp_sync[$];

  typedef struct {
    int per;
    int dd;
    int gc;
    int level;
    int ovr;
  } row_t;

  row_t rows[8];

  game_sequencer_if bus ();

  game_sequencer #(
    .TICK_BASE(20),
    .SPEED_STEP(4),
    .SPEED_LEVELS(4),
    .APPLES_PER_LEVEL(4)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic [5:0] m);
    {bus.start, bus.pause, bus.goodColl, bus.badColl, bus.isGameComplete, bus.draw_done} = m;
    @(negedge clk);
    {bus.start, bus.pause, bus.goodColl, bus.badColl, bus.isGameComplete, bus.draw_done} = 6'b0;
  endtask

  // Sync scoreboard: every strobe must match the next predicted cycle
  always @(negedge clk) begin
    if (nrst && bus.sync) begin
      if (exp_sync.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sync: got sync at cycle %0d expected none", cyc);
      end else begin
        check("sync_cycle", cyc, exp_sync.pop_front());
      end
      check("sync_sreset_excl", bus.s_reset, 0);
    end
  end

  initial begin
    int s;
    int nxt;
    int u;

    // per = period of the tick starting at this row's sync; dd = draw_done delay
    rows[0] = '{per: 20, dd: 3,  gc: 0, level: 0, ovr: 0};
    rows[1] = '{per: 20, dd: 3,  gc: 4, level: 1, ovr: 0};
    rows[2] = '{per: 16, dd: 3,  gc: 4, level: 2, ovr: 0};
    rows[3] = '{per: 12, dd: 3,  gc: 4, level: 3, ovr: 0};
    rows[4] = '{per: 8,  dd: 3,  gc: 4, level: 3, ovr: 0};
    rows[5] = '{per: 8,  dd: 3,  gc: 4, level: 3, ovr: 0};
    rows[6] = '{per: 8,  dd: 25, gc: 0, level: 3, ovr: 1};
    rows[7] = '{per: 8,  dd: 3,  gc: 0, level: 3, ovr: 1};

    checks = 0;
    errors = 0;
    nrst   = 1'b0;
    {bus.start, bus.pause, bus.goodColl, bus.badColl, bus.isGameComplete, bus.draw_done} = 6'b0;
    repeat (3) @(negedge clk);

    check("rst_state", bus.state, 0);
    check("rst_sync", bus.sync, 0);
    check("rst_s_reset", bus.s_reset, 0);
    check("rst_draw_req", bus.draw_req, 0);
    check("rst_speed", bus.speed_level, 0);
    check("rst_overrun", bus.overrun, 0);

    // Start at cycle 0: soft reset pulse at cycle 1 only, first sync 20 cycles after RUN entry
    nrst = 1'b1;
    exp_sync.push_back(21);
    pulse(P_START);
    check("start_s_reset", bus.s_reset, 1);
    check("start_state", bus.state, 1);
    @(negedge clk);
    check("start_s_reset_drop", bus.s_reset, 0);
    idle_to(21);

    for (int i = 0; i < 8; i++) begin
      s = cyc;
      check("tick_state", bus.state, 2);
      check("tick_draw_req", bus.draw_req, 1);
      if (rows[i].dd >= rows[i].per) nxt = s + rows[i].dd + 2;
      else                           nxt = s + rows[i].per;
      exp_sync.push_back(nxt);
      if (rows[i].dd >= rows[i].per) begin
        idle_to(s + rows[i].per - 1);
        check("overrun_pre", bus.overrun, 0);
        idle_to(s + rows[i].per);
        check("overrun_set", bus.overrun, 1);
      end
      idle_to(s + rows[i].dd);
      pulse(P_DONE);
      check("done_draw_req", bus.draw_req, 0);
      check("done_state", bus.state, 1);
      for (int k = 0; k < rows[i].gc; k++) pulse(P_GOOD);
      check("speed_level", bus.speed_level, rows[i].level);
      check("overrun", bus.overrun, rows[i].ovr);
      idle_to(nxt);
    end

    // Pause latched during DRAW is taken at draw_done; counter 4 resumes, period 8
    s = cyc;
    exp_sync.push_back(s + 15);
    idle_to(s + 1);
    pulse(P_PAUSE);
    idle_to(s + 3);
    pulse(P_DONE);
    check("draw_pause_state", bus.state, 3);
    check("draw_pause_req", bus.draw_req, 0);
    idle_to(s + 10);
    pulse(P_PAUSE);
    check("draw_pause_resume", bus.state, 1);
    idle_to(s + 15);
    check("post_pause_tick", bus.state, 2);

    // Both terminal events together in RUN: OVER wins, nothing ticks afterwards
    idle_to(s + 18);
    pulse(P_DONE);
    idle_to(s + 20);
    pulse(P_BAD | P_WIN);
    check("over_state", bus.state, 4);
    check("over_draw_req", bus.draw_req, 0);
    idle_to(s + 25);
    pulse(P_GOOD | P_PAUSE);
    check("over_ignores_state", bus.state, 4);
    check("over_ignores_speed", bus.speed_level, 3);
    idle_to(s + 121);
    check("over_overrun_sticky", bus.overrun, 1);

    // Restart from OVER, then pause at counter 7 for 50 cycles
    u = cyc;
    pulse(P_START);
    check("restart_s_reset", bus.s_reset, 1);
    check("restart_speed", bus.speed_level, 0);
    check("restart_overrun", bus.overrun, 0);
    check("restart_state", bus.state, 1);
    @(negedge clk);
    check("restart_s_reset_drop", bus.s_reset, 0);
    idle_to(u + 8);
    pulse(P_PAUSE);
    check("pause_state", bus.state, 3);
    idle_to(u + 58);
    check("pause_hold", bus.state, 3);
    exp_sync.push_back(u + 72);
    pulse(P_PAUSE);
    check("pause_resume", bus.state, 1);
    idle_to(u + 72);
    check("resume_tick", bus.state, 2);

    // Board full together with draw_done in DRAW: terminal wins
    pulse(P_WIN | P_DONE);
    check("win_state", bus.state, 5);
    check("win_draw_req", bus.draw_req, 0);
    idle_to(u + 104);

    // Asynchronous reset in the middle of a redraw drops draw_req at once
    s = cyc;
    exp_sync.push_back(s + 21);
    pulse(P_START);
    idle_to(s + 21);
    check("pre_reset_draw_req", bus.draw_req, 1);
    idle_to(s + 22);
    nrst = 1'b0;
    #1;
    check("async_draw_req", bus.draw_req, 0);
    check("async_state", bus.state, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    check("sync_queue_drained", exp_sync.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
